// File: rtl/itlb_refill_ctrl_pkg.sv
// Shared types and constants for the ITLB refill path: FSM states, Sv39 PTE
// layout and the instruction-fetch legality check applied to walked PTEs.
package itlb_refill_ctrl_pkg;

  localparam int MXLEN        = 64;
  localparam int ITLB_ENTRIES = 8;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } itlb_refill_state_e;

  // W without R is a reserved encoding and is rejected like a missing X.
  function automatic logic pte_fetch_legal(input pte_t pte, input logic walk_fault);
    return !walk_fault && pte[PTE_V] && pte[PTE_X] && !(pte[PTE_W] && !pte[PTE_R]);
  endfunction

endpackage

// File: rtl/itlb_refill_ctrl_victim_sel.sv
// Combinational victim picker: lowest-index invalid line, otherwise the
// round-robin pointer supplied by the controller.
module itlb_victim_sel #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] entry_valid_i,
  input  logic [IDX_W-1:0]   rr_i,
  output logic [ENTRIES-1:0] victim_oh_o,
  output logic [IDX_W-1:0]   victim_idx_o,
  output logic               use_rr_o
);

  always_comb begin
    use_rr_o     = &entry_valid_i;
    victim_idx_o = rr_i;
    // Scanning downward leaves the lowest invalid index as the final winner.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!entry_valid_i[i]) victim_idx_o = IDX_W'(i);
    end
    victim_oh_o               = '0;
    victim_oh_o[victim_idx_o] = 1'b1;
  end

endmodule

// File: rtl/itlb_refill_ctrl.sv
// ITLB refill controller: walks on a miss, checks fetch legality of the leaf
// PTE and writes it into a victim line, honouring flushes at every step.
module itlb_refill_ctrl
  import itlb_refill_ctrl_pkg::*;
#(
  parameter int ENTRIES = ITLB_ENTRIES,
  parameter int VPN_W   = 27,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               miss_valid_i,
  input  logic [VPN_W-1:0]   miss_vpn_i,
  output logic               miss_ready_o,
  output logic               ptw_req_valid_o,
  input  logic               ptw_req_ready_i,
  output logic [VPN_W-1:0]   ptw_req_vpn_o,
  input  logic               ptw_resp_valid_i,
  input  pte_t               ptw_resp_pte_i,
  input  logic               ptw_resp_fault_i,
  input  logic [ENTRIES-1:0] entry_valid_i,
  input  logic               flush_i,
  output logic [ENTRIES-1:0] wr_en_o,
  output logic [IDX_W-1:0]   wr_idx_o,
  output logic [VPN_W-1:0]   wr_vpn_o,
  output pte_t               wr_pte_o,
  output logic               refill_done_o,
  output logic               refill_fault_o,
  output logic               busy_o
);

  itlb_refill_state_e state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [VPN_W-1:0]   vpn_q, vpn_d;
  pte_t               pte_q, pte_d;
  logic               drop_q, drop_d;
  logic               fault_q, fault_d;

  logic [ENTRIES-1:0] victim_oh;
  logic [IDX_W-1:0]   victim_idx;
  logic               use_rr;
  logic               resp_legal;
  logic               do_write;

  itlb_victim_sel #(
    .ENTRIES(ENTRIES),
    .IDX_W  (IDX_W)
  ) u_victim_sel (
    .entry_valid_i(entry_valid_i),
    .rr_i         (rr_q),
    .victim_oh_o  (victim_oh),
    .victim_idx_o (victim_idx),
    .use_rr_o     (use_rr)
  );

  assign resp_legal = pte_fetch_legal(ptw_resp_pte_i, ptw_resp_fault_i);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      vpn_q   <= '0;
      pte_q   <= '0;
      drop_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      vpn_q   <= vpn_d;
      pte_q   <= pte_d;
      drop_q  <= drop_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    vpn_d   = vpn_q;
    pte_d   = pte_q;
    drop_d  = drop_q;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_valid_i && !flush_i) begin
          vpn_d   = miss_vpn_i;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Once the walker has the request its response must still be drained.
        if (ptw_req_ready_i) begin
          state_d = ST_WAIT;
          if (flush_i) drop_d = 1'b1;
        end else if (flush_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (flush_i) drop_d = 1'b1;
        if (ptw_resp_valid_i) begin
          pte_d = ptw_resp_pte_i;
          if (drop_q || flush_i) begin
            state_d = ST_IDLE;
          end else if (resp_legal) begin
            state_d = ST_WRITE;
          end else begin
            fault_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        if (!flush_i && use_rr) rr_d = rr_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) drop_d = 1'b0;
  end

  always_comb begin
    do_write        = (state_q == ST_WRITE) && !flush_i;
    miss_ready_o    = (state_q == ST_IDLE) && !flush_i;
    ptw_req_valid_o = (state_q == ST_REQ);
    busy_o          = (state_q != ST_IDLE);
    refill_done_o   = do_write;
    refill_fault_o  = fault_q;
    wr_en_o         = do_write ? victim_oh : '0;
  end

  assign ptw_req_vpn_o = vpn_q;
  assign wr_idx_o      = victim_idx;
  assign wr_vpn_o      = vpn_q;
  assign wr_pte_o      = pte_q;

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Directed bench for itlb_refill_ctrl with hand-computed expectations.
module tb_itlb_refill_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        miss_valid;
  logic [26:0] miss_vpn;
  logic        miss_ready;
  logic        req_valid;
  logic        req_ready;
  logic [26:0] req_vpn;
  logic        resp_valid;
  logic [63:0] resp_pte;
  logic        resp_fault;
  logic [7:0]  entry_valid;
  logic        flush;
  logic [7:0]  wr_en;
  logic [2:0]  wr_idx;
  logic [26:0] wr_vpn;
  logic [63:0] wr_pte;
  logic        done;
  logic        fault;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  itlb_refill_ctrl dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .miss_valid_i    (miss_valid),
    .miss_vpn_i      (miss_vpn),
    .miss_ready_o    (miss_ready),
    .ptw_req_valid_o (req_valid),
    .ptw_req_ready_i (req_ready),
    .ptw_req_vpn_o   (req_vpn),
    .ptw_resp_valid_i(resp_valid),
    .ptw_resp_pte_i  (resp_pte),
    .ptw_resp_fault_i(resp_fault),
    .entry_valid_i   (entry_valid),
    .flush_i         (flush),
    .wr_en_o         (wr_en),
    .wr_idx_o        (wr_idx),
    .wr_vpn_o        (wr_vpn),
    .wr_pte_o        (wr_pte),
    .refill_done_o   (done),
    .refill_fault_o  (fault),
    .busy_o          (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    step;
    rstn = 1'b1;
    #1;
  endtask

  // exp_en == 0 means the PTE must be rejected with a fault pulse.
  task automatic refill(input string tag, input logic [26:0] vpn, input logic [63:0] pte,
                        input logic flt, input logic [7:0] ev, input int wcyc,
                        input logic [7:0] exp_en);
    entry_valid = ev;
    miss_valid  = 1'b1;
    miss_vpn    = vpn;
    req_ready   = 1'b1;
    #1;
    chk({tag, ":miss_ready"}, miss_ready, 1);
    step;
    miss_valid = 1'b0;
    #1;
    chk({tag, ":req_valid"}, req_valid, 1);
    chk({tag, ":req_vpn"}, req_vpn, vpn);
    step;
    repeat (wcyc) begin
      chk({tag, ":wait_wr_en"}, wr_en, 0);
      step;
    end
    resp_valid = 1'b1;
    resp_pte   = pte;
    resp_fault = flt;
    #1;
    chk({tag, ":busy_wait"}, busy, 1);
    step;
    resp_valid = 1'b0;
    resp_fault = 1'b0;
    #1;
    if (exp_en != 8'h00) begin
      chk({tag, ":wr_en"}, wr_en, exp_en);
      chk({tag, ":done"}, done, 1);
      chk({tag, ":wr_vpn"}, wr_vpn, vpn);
      chk({tag, ":wr_pte"}, wr_pte, pte);
    end else begin
      chk({tag, ":wr_en_f"}, wr_en, 0);
      chk({tag, ":done_f"}, done, 0);
      chk({tag, ":fault"}, fault, 1);
      chk({tag, ":busy_f"}, busy, 0);
    end
    step;
    chk({tag, ":idle_busy"}, busy, 0);
    chk({tag, ":idle_ready"}, miss_ready, 1);
    chk({tag, ":idle_pulses"}, {done, fault}, 0);
  endtask

  initial begin
    rstn        = 1'b0;
    miss_valid  = 1'b0;
    miss_vpn    = '0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_pte    = '0;
    resp_fault  = 1'b0;
    entry_valid = 8'hFF;
    flush       = 1'b0;
    step;
    step;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_pulses", {done, fault}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miss_ready", miss_ready, 1);
    chk("rst_rr", dut.rr_q, 0);
    rstn = 1'b1;
    #1;

    // Response two cycles into WAIT lands in cycle 4, write in cycle 5.
    refill("basic", 27'h12345, 64'hCB, 1'b0, 8'hFF, 2, 8'h01);
    chk("basic_rr", dut.rr_q, 1);
    chk("basic_idx", wr_idx, 1);

    refill("invfirst", 27'h00ABC, 64'hCB, 1'b0, 8'hF3, 0, 8'h04);
    chk("invfirst_rr", dut.rr_q, 1);

    do_reset;
    for (int i = 0; i < 9; i++) begin
      refill($sformatf("rr%0d", i), 27'(32'h100 + i), 64'hCB, 1'b0, 8'hFF, 0, 8'(1 << (i % 8)));
    end
    chk("rr_wrap", dut.rr_q, 1);

    refill("flt_x0", 27'h00011, 64'h07, 1'b0, 8'hFF, 1, 8'h00);
    refill("flt_walk", 27'h00022, 64'hCB, 1'b1, 8'hFF, 0, 8'h00);
    refill("flt_wnr", 27'h00033, 64'h0D, 1'b0, 8'hFF, 0, 8'h00);
    refill("flt_v0", 27'h00044, 64'hCA, 1'b0, 8'hFF, 0, 8'h00);
    chk("flt_rr", dut.rr_q, 1);

    // Flush while waiting: response 3 cycles later is swallowed.
    miss_valid = 1'b1; miss_vpn = 27'h0BEEF; req_ready = 1'b1;
    step;
    miss_valid = 1'b0;
    step;
    flush = 1'b1;
    step;
    flush = 1'b0;
    step;
    chk("fw_busy1", busy, 1);
    step;
    chk("fw_busy2", busy, 1);
    resp_valid = 1'b1; resp_pte = 64'hCB;
    step;
    resp_valid = 1'b0;
    #1;
    chk("fw_busy_drop", busy, 0);
    chk("fw_wr_en", wr_en, 0);
    chk("fw_pulses", {done, fault}, 0);
    refill("after_fw", 27'h0CAFE, 64'hCB, 1'b0, 8'hFF, 0, 8'h02);

    // Flush in REQ without handshake: no request remains outstanding.
    miss_valid = 1'b1; miss_vpn = 27'h00555; req_ready = 1'b0;
    step;
    miss_valid = 1'b0; flush = 1'b1;
    #1;
    chk("freq_valid", req_valid, 1);
    step;
    flush = 1'b0;
    #1;
    chk("freq_busy", busy, 0);
    chk("freq_valid_off", req_valid, 0);

    // Flush in REQ with handshake: response is drained silently.
    miss_valid = 1'b1; miss_vpn = 27'h00666; req_ready = 1'b1;
    step;
    miss_valid = 1'b0; flush = 1'b1;
    step;
    flush = 1'b0;
    chk("frh_busy", busy, 1);
    resp_valid = 1'b1; resp_pte = 64'hCB;
    step;
    resp_valid = 1'b0;
    #1;
    chk("frh_busy_drop", busy, 0);
    chk("frh_wr", {wr_en, done, fault}, 0);

    // Flush in IDLE blocks acceptance.
    flush = 1'b1; miss_valid = 1'b1;
    #1;
    chk("fidle_ready", miss_ready, 0);
    step;
    miss_valid = 1'b0; flush = 1'b0;
    #1;
    chk("fidle_busy", busy, 0);

    // Flush in WRITE suppresses the write and keeps rr.
    miss_valid = 1'b1; miss_vpn = 27'h00777; req_ready = 1'b1;
    step;
    miss_valid = 1'b0;
    step;
    resp_valid = 1'b1; resp_pte = 64'hCB;
    step;
    resp_valid = 1'b0; flush = 1'b1;
    #1;
    chk("fwr_wr_en", wr_en, 0);
    chk("fwr_done", done, 0);
    step;
    flush = 1'b0;
    #1;
    chk("fwr_busy", busy, 0);
    chk("fwr_rr", dut.rr_q, 2);

    // Walker backpressure then reset in WAIT.
    miss_valid = 1'b1; miss_vpn = 27'h7ABCD; req_ready = 1'b0;
    step;
    miss_valid = 1'b0; miss_vpn = 27'h0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid%0d", i), req_valid, 1);
      chk($sformatf("bp_vpn%0d", i), req_vpn, 27'h7ABCD);
      step;
    end
    req_ready = 1'b1;
    #1;
    chk("bp_valid_hs", req_valid, 1);
    step;
    req_ready = 1'b0;
    #1;
    chk("bp_wait_busy", busy, 1);
    chk("bp_wait_valid", req_valid, 0);
    do_reset;
    chk("rw_outs", {wr_en, req_valid, done, fault, busy}, 0);
    chk("rw_ready", miss_ready, 1);
    chk("rw_rr", dut.rr_q, 0);
    resp_valid = 1'b1; resp_pte = 64'hCB;
    step;
    resp_valid = 1'b0;
    #1;
    chk("rw_ignored", {wr_en, done, fault, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
